// File: rtl/airplane_motion_ctrl.sv
// Frame-synchronous sprite x-position generator for the VGA renderer (advances only on frame_tick).
// Edge handling wraps around by default; define AIRPLANE_BOUNCE_EN to bounce with a hold at each edge.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_PAUSE | frozen; resumes the saved state when run is set
//   ST_MOVE  | counting frame_ticks, one position step per FRAMES_PER_STEP
//   ST_TURN  | parked at a screen edge for TURN_FRAMES, then reverses
module airplane_motion_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int SPRITE_W        = 32,
    parameter int STEP_SLOW       = 1,
    parameter int STEP_FAST       = 4,
    parameter int FRAMES_PER_STEP = 2,
    parameter int TURN_FRAMES     = 8,
    parameter int X_RESET         = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [2:0] sw,
    output logic [9:0] airplanex,
    output logic       dir,
    output logic       moving,
    output logic       step_pulse
);

    localparam int             XMAX    = H_ACTIVE - SPRITE_W;
    localparam int             FCW     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [10:0]    XMAX_W  = 11'(XMAX);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);

    if (FRAMES_PER_STEP < 1) begin : g_chk_fps
        $error("airplane_motion_ctrl: FRAMES_PER_STEP must be at least 1");
    end
    if (TURN_FRAMES < 1) begin : g_chk_turn
        $error("airplane_motion_ctrl: TURN_FRAMES must be at least 1");
    end
    if (X_RESET < 0 || X_RESET > XMAX || XMAX > 1023) begin : g_chk_xrange
        $error("airplane_motion_ctrl: X_RESET or XMAX out of range");
    end

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_MOVE  = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         r_saved;
    logic [2:0]     r_sw_meta;
    logic [2:0]     r_sw_sync;
    logic           r_sw1_prev;
    logic           r_dir_pend;
    logic           r_dir;
    logic           r_moving;
    logic           r_step_pulse;
    logic [9:0]     r_x;
    logic [FCW-1:0] r_frame_cnt;

    logic           w_run;
    logic           w_toggle;
    logic           w_dir_eff;
    logic [10:0]    w_step;
    logic [10:0]    w_x_ext;
    logic [9:0]     w_next_x;

`ifdef AIRPLANE_BOUNCE_EN
    localparam int             TCW     = $clog2(TURN_FRAMES + 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(TURN_FRAMES - 1);
    localparam logic [9:0]     XMAX_X  = 10'(XMAX);

    logic [TCW-1:0] r_turn_cnt;
    logic           w_hit_edge;
`endif

    assign w_run     = r_sw_sync[0];
    assign w_toggle  = r_sw_sync[1] ^ r_sw1_prev;
    // A direction request waiting for the next step boundary is applied to that step.
    assign w_dir_eff = r_dir ^ r_dir_pend;
    assign w_step    = r_sw_sync[2] ? 11'(STEP_FAST) : 11'(STEP_SLOW);
    assign w_x_ext   = {1'b0, r_x};

    always_comb begin
        w_next_x = r_x;
        if (!w_dir_eff) begin
            if ((w_x_ext + w_step) > XMAX_W)
                w_next_x = 10'(w_x_ext + w_step - XMAX_W - 11'd1);
            else
                w_next_x = 10'(w_x_ext + w_step);
        end else begin
            if (w_x_ext < w_step)
                w_next_x = 10'(w_x_ext + XMAX_W + 11'd1 - w_step);
            else
                w_next_x = 10'(w_x_ext - w_step);
        end
    end

`ifdef AIRPLANE_BOUNCE_EN
    assign w_hit_edge = w_dir_eff ? (w_x_ext <= w_step) : ((w_x_ext + w_step) >= XMAX_W);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
            r_sw1_prev   <= 1'b0;
            r_dir_pend   <= 1'b0;
            r_state      <= ST_PAUSE;
            r_saved      <= ST_MOVE;
            r_frame_cnt  <= '0;
            r_x          <= 10'(X_RESET);
            r_dir        <= 1'b0;
            r_moving     <= 1'b0;
            r_step_pulse <= 1'b0;
`ifdef AIRPLANE_BOUNCE_EN
            r_turn_cnt   <= '0;
`endif
        end else begin
            r_sw_meta    <= sw;
            r_sw_sync    <= r_sw_meta;
            r_sw1_prev   <= r_sw_sync[1];
            r_step_pulse <= 1'b0;
            if (w_toggle)
                r_dir_pend <= ~r_dir_pend;

            case (r_state)
                ST_PAUSE: begin
                    if (w_run) begin
                        r_state  <= r_saved;
                        r_moving <= (r_saved == ST_MOVE);
                    end
                end
                ST_MOVE: begin
                    // A pause request beats a coincident frame_tick.
                    if (!w_run) begin
                        r_state  <= ST_PAUSE;
                        r_saved  <= ST_MOVE;
                        r_moving <= 1'b0;
                    end else if (frame_tick) begin
                        if (r_frame_cnt == FC_LAST) begin
                            r_frame_cnt  <= '0;
                            r_step_pulse <= 1'b1;
                            r_dir        <= w_dir_eff;
                            r_dir_pend   <= w_toggle;
`ifdef AIRPLANE_BOUNCE_EN
                            if (w_hit_edge) begin
                                r_x        <= w_dir_eff ? 10'd0 : XMAX_X;
                                r_state    <= ST_TURN;
                                r_moving   <= 1'b0;
                                r_turn_cnt <= '0;
                            end else begin
                                r_x <= w_next_x;
                            end
`else
                            r_x <= w_next_x;
`endif
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FCW'(1);
                        end
                    end
                end
`ifdef AIRPLANE_BOUNCE_EN
                ST_TURN: begin
                    if (!w_run) begin
                        r_state  <= ST_PAUSE;
                        r_saved  <= ST_TURN;
                        r_moving <= 1'b0;
                    end else if (frame_tick) begin
                        if (r_turn_cnt == TC_LAST) begin
                            r_turn_cnt <= '0;
                            r_dir      <= ~r_dir;
                            r_state    <= ST_MOVE;
                            r_moving   <= 1'b1;
                        end else begin
                            r_turn_cnt <= r_turn_cnt + TCW'(1);
                        end
                    end
                end
`endif
                default: begin
                    r_state  <= ST_PAUSE;
                    r_moving <= 1'b0;
                end
            endcase
        end
    end

    assign airplanex  = r_x;
    assign dir        = r_dir;
    assign moving     = r_moving;
    assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_airplane_motion_ctrl.sv
// Directed bench for airplane_motion_ctrl: behavioural model feeds a scoreboard of expected positions.
// Follows the build's AIRPLANE_BOUNCE_EN setting for the edge-handling scenarios.
module tb_airplane_motion_ctrl;

    localparam int XMAX        = 608;
    localparam int STEP_SLOW   = 1;
    localparam int STEP_FAST   = 4;
    localparam int FPS         = 2;
    localparam int TURN_FRAMES = 8;
    localparam int MS_PAUSE    = 0;
    localparam int MS_MOVE     = 1;
    localparam int MS_TURN     = 2;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [2:0] sw;
    logic [9:0] airplanex;
    logic       dir;
    logic       moving;
    logic       step_pulse;

    int         total;
    int         bad;
    int         pulses;
    int         sb[$];

    int         m_x;
    int         m_fcnt;
    int         m_tcnt;
    int         m_state;
    int         m_saved;
    bit         m_dir;
    bit         m_pend;
    logic [2:0] m_sw;

    airplane_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .sw         (sw),
        .airplanex  (airplanex),
        .dir        (dir),
        .moving     (moving),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        int e;
        if (reset === 1'b1 && step_pulse === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_unexpected_step observed=%0d expected=no_step", airplanex);
            end else begin
                e = sb.pop_front();
                chk("sb_x", 32'(airplanex), 32'(e));
            end
        end
    end

    task automatic model_reset();
        m_x     = 0;
        m_fcnt  = 0;
        m_tcnt  = 0;
        m_state = MS_PAUSE;
        m_saved = MS_MOVE;
        m_dir   = 1'b0;
        m_pend  = 1'b0;
        m_sw    = 3'b000;
    endtask

    // Drive the switches and wait for the synchroniser and FSM to settle.
    task automatic set_sw(input logic [2:0] v);
        if (v[1] !== m_sw[1]) m_pend = ~m_pend;
        sw = v;
        repeat (3) @(posedge clk);
        #1;
        if (v[0] && m_state == MS_PAUSE) begin
            m_state = m_saved;
        end else if (!v[0] && m_state != MS_PAUSE) begin
            m_saved = m_state;
            m_state = MS_PAUSE;
        end
        m_sw = v;
        chk("moving_after_sw", 32'(moving), 32'(m_state == MS_MOVE));
    endtask

    task automatic tick();
        logic exp_step;
        int   s;
        exp_step = 1'b0;
        s = m_sw[2] ? STEP_FAST : STEP_SLOW;
        if (m_state == MS_MOVE) begin
            if (m_fcnt == FPS - 1) begin
                m_fcnt   = 0;
                exp_step = 1'b1;
                m_dir    = m_dir ^ m_pend;
                m_pend   = 1'b0;
`ifdef AIRPLANE_BOUNCE_EN
                if (!m_dir && m_x + s >= XMAX) begin
                    m_x = XMAX; m_state = MS_TURN; m_tcnt = 0;
                end else if (m_dir && m_x <= s) begin
                    m_x = 0; m_state = MS_TURN; m_tcnt = 0;
                end else begin
                    m_x = m_dir ? m_x - s : m_x + s;
                end
`else
                if (!m_dir) m_x = (m_x + s > XMAX) ? m_x + s - (XMAX + 1) : m_x + s;
                else        m_x = (m_x < s) ? m_x + (XMAX + 1) - s : m_x - s;
`endif
                sb.push_back(m_x);
            end else begin
                m_fcnt++;
            end
        end else if (m_state == MS_TURN) begin
            m_tcnt++;
            if (m_tcnt == TURN_FRAMES) begin
                m_dir = ~m_dir; m_state = MS_MOVE; m_tcnt = 0;
            end
        end
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        chk("step_pulse", 32'(step_pulse), 32'(exp_step));
        chk("moving", 32'(moving), 32'(m_state == MS_MOVE));
        chk("dir", 32'(dir), 32'(m_dir));
        if (!exp_step) chk("x_hold", 32'(airplanex), 32'(m_x));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int p0;
        total      = 0;
        bad        = 0;
        pulses     = 0;
        reset      = 1'b0;
        frame_tick = 1'b0;
        sw         = 3'b000;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", 32'(airplanex), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_step", 32'(step_pulse), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ticks while paused after reset are ignored.
        tick();
        tick();

        // Slow run from 0: ten ticks give five steps.
        set_sw(3'b001);
        p0 = pulses;
        repeat (10) tick();
        chk("x_after_10", 32'(airplanex), 32'd5);
        chk("pulse_count_10", 32'(pulses - p0), 32'd5);

        // Pause arrives (synchronised) in the same cycle as a step's frame_tick.
        tick();
        sw = 3'b000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        m_saved = MS_MOVE;
        m_state = MS_PAUSE;
        m_sw    = 3'b000;
        chk("pause_no_step", 32'(step_pulse), 32'd0);
        chk("pause_moving", 32'(moving), 32'd0);
        chk("pause_x", 32'(airplanex), 32'd5);
        @(posedge clk);
        #1;
        tick();
        set_sw(3'b001);
        tick();
        chk("resume_x", 32'(airplanex), 32'd6);

        // Reach x=100, then toggle direction between steps.
        set_sw(3'b101);
        repeat (46) tick();
        set_sw(3'b001);
        repeat (4) tick();
        chk("x_at_100", 32'(airplanex), 32'd100);
        set_sw(3'b011);
        chk("dir_deferred", 32'(dir), 32'd0);
        repeat (2) tick();
        chk("x_left_99", 32'(airplanex), 32'd99);
        chk("dir_left", 32'(dir), 32'd1);

        // Back to the right up to 300, leave a direction change pending, then reset mid-step.
        set_sw(3'b101);
        repeat (100) tick();
        set_sw(3'b001);
        repeat (2) tick();
        chk("x_at_300", 32'(airplanex), 32'd300);
        set_sw(3'b011);
        tick();
        frame_tick = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_x", 32'(airplanex), 32'd0);
        chk("async_rst_dir", 32'(dir), 32'd0);
        chk("async_rst_moving", 32'(moving), 32'd0);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        sw = 3'b000;
        chk("mid_rst_x", 32'(airplanex), 32'd0);
        chk("mid_rst_step", 32'(step_pulse), 32'd0);
        chk("mid_rst_moving", 32'(moving), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        sb.delete();
        @(posedge clk);
        #1;

        // Screen-edge handling.
        set_sw(3'b001);
        repeat (4) tick();
        chk("x_at_2", 32'(airplanex), 32'd2);
        set_sw(3'b101);
        repeat (302) tick();
        chk("x_at_606", 32'(airplanex), 32'd606);
        repeat (2) tick();
`ifdef AIRPLANE_BOUNCE_EN
        chk("bounce_x_max", 32'(airplanex), 32'd608);
        chk("bounce_moving", 32'(moving), 32'd0);
        repeat (7) tick();
        chk("turn_dir_held", 32'(dir), 32'd0);
        tick();
        chk("turn_dir_flip", 32'(dir), 32'd1);
        chk("turn_moving", 32'(moving), 32'd1);
        repeat (2) tick();
        chk("bounce_x_604", 32'(airplanex), 32'd604);
`else
        chk("wrap_right_x", 32'(airplanex), 32'd1);
        set_sw(3'b001);
        repeat (2) tick();
        chk("x_back_2", 32'(airplanex), 32'd2);
        set_sw(3'b111);
        repeat (2) tick();
        chk("wrap_left_x", 32'(airplanex), 32'd607);
        chk("wrap_left_dir", 32'(dir), 32'd1);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
